// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage load-use / flag hazard scoreboard with taken-branch flush sequencer
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   if_id_inst, if_id_valid     instruction held in ID and its valid bit
//   id_rd_addr, id_mem_read     destination register and load flag of the ID instruction
//   id_flag_write               ID instruction writes the condition flags
//   br_taken                    branch in ID resolved taken
//   stall, pc_write, id_flush   hold PC and IF/ID, PC write enable, ID/EX bubble
//   if_flush                    squash IF/ID
//   stall_cnt                   saturating count of stall cycles
// Field extraction assumes REG_AW <= 4 (register fields are 4 bits wide in the encoding).
module hazard_scoreboard #(
    parameter int unsigned REG_AW     = 4,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned FLAG_LAT   = 2,
    parameter int unsigned BR_PENALTY = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       if_id_inst,
    input  logic              if_id_valid,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              id_mem_read,
    input  logic              id_flag_write,
    input  logic              br_taken,
    output logic              stall,
    output logic              pc_write,
    output logic              id_flush,
    output logic              if_flush,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int unsigned NUM_REGS = 2 ** REG_AW;
    typedef enum logic {IDLE, FLUSH} state_t;
    state_t            state_q, state_d;
    logic [1:0]        fcnt_q, fcnt_d;
    logic [2:0]        ld_cnt_q [NUM_REGS];
    logic [2:0]        ld_cnt_d [NUM_REGS];
    logic [2:0]        flag_cnt_q, flag_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [3:0]        op;
    logic              is_mem_br, uses_rs, uses_rt, cond_br;
    logic [REG_AW-1:0] rs, rt;
    logic              in_flush, hazard, issue, br_go;

    assign op        = if_id_inst[15:12];
    assign is_mem_br = (op == 4'b1000) || (op == 4'b1001);
    assign rs        = if_id_inst[4 +: REG_AW];
    assign rt        = is_mem_br ? if_id_inst[8 +: REG_AW] : if_id_inst[0 +: REG_AW];
    assign uses_rs   = !if_id_inst[15] || is_mem_br || (op == 4'b1101);
    assign uses_rt   = !if_id_inst[15] || is_mem_br;
    assign cond_br   = (if_id_inst[15:13] == 3'b110) && (if_id_inst[11:9] != 3'b111);

    assign in_flush = (state_q == FLUSH);
    assign hazard   = (uses_rs && rs != '0 && ld_cnt_q[rs] != 3'd0) ||
                      (uses_rt && rt != '0 && ld_cnt_q[rt] != 3'd0) ||
                      (cond_br && flag_cnt_q != 3'd0);
    // rst_n gating keeps the outputs quiet during reset even though inputs may still toggle
    assign stall     = rst_n && if_id_valid && !in_flush && hazard;
    assign pc_write  = !stall;
    assign id_flush  = stall;
    assign issue     = if_id_valid && !stall;
    assign br_go     = !in_flush && br_taken && !stall;
    assign if_flush  = rst_n && (in_flush || br_go);
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++)
            ld_cnt_d[r] = (ld_cnt_q[r] != 3'd0) ? ld_cnt_q[r] - 3'd1 : 3'd0;
        // a fresh load overrides the decrement on its own register
        if (issue && id_mem_read && id_rd_addr != '0)
            ld_cnt_d[id_rd_addr] = 3'(LOAD_LAT);
        flag_cnt_d  = (issue && id_flag_write) ? 3'(FLAG_LAT) :
                      (flag_cnt_q != 3'd0) ? flag_cnt_q - 3'd1 : 3'd0;
        stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        state_d     = in_flush ? ((fcnt_q == 2'd1) ? IDLE : FLUSH) :
                      ((br_go && BR_PENALTY > 1) ? FLUSH : IDLE);
        fcnt_d      = in_flush ? fcnt_q - 2'd1 : (br_go ? 2'(BR_PENALTY - 1) : 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++)
                ld_cnt_q[r] <= 3'd0;
            flag_cnt_q  <= 3'd0;
            stall_cnt_q <= '0;
            state_q     <= IDLE;
            fcnt_q      <= 2'd0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                ld_cnt_q[r] <= ld_cnt_d[r];
            flag_cnt_q  <= flag_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
        end
    end
endmodule
